// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiplier and restoring divider.
package mul_div_pkg;

    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/twos_abs_neg.sv
// Conditional two's-complement negate: data_o = neg_i ? -data_i : data_i.
module twos_abs_neg #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] data_i,
    input  logic         neg_i,
    output logic [W-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (neg_i) begin
            data_o = ~data_i + W'(1);
        end
    end

endmodule

// File: rtl/mul_no_pipeline.sv
// Shift-and-add WIDTH x WIDTH multiplier: one partial-product bit per cycle, fixed latency.
module mul_no_pipeline
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned sign  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               ready
);

    localparam logic SIGNED_OPS = (sign != 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fixed;

    // |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit magnitude.
    twos_abs_neg #(.W(WIDTH)) u_abs_a (
        .data_i (multiplicand),
        .neg_i  (SIGNED_OPS & multiplicand[WIDTH-1]),
        .data_o (mag_a)
    );

    twos_abs_neg #(.W(WIDTH)) u_abs_b (
        .data_i (multiplier),
        .neg_i  (SIGNED_OPS & multiplier[WIDTH-1]),
        .data_o (mag_b)
    );

    twos_abs_neg #(.W(2*WIDTH)) u_fix (
        .data_i (acc_q),
        .neg_i  (neg_q),
        .data_o (prod_fixed)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        product_d = product_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = SIGNED_OPS & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    count_d  = CNT_W'(WIDTH);
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                product_d = prod_fixed;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign product = product_q;
    assign ready   = ready_q;
    assign busy    = busy_q;

endmodule
